// File: rtl/axi4_lite_wr_manager.sv
// axi4_lite_wr_manager: single-outstanding AXI4-Lite write manager (local cmd/rsp ports to AW/W/B).
// Optional B-channel timeout is built when AXI_WR_TIMEOUT_EN is defined.
module axi4_lite_wr_manager #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [7:0]              err_count,
    output logic                    busy,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_B, RSP} state_t;

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("axi4_lite_wr_manager: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
    end

    state_t                    state_q, state_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      bready_q, bready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic [7:0]                err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      b_hs;
    logic                      expired;
    logic                      timeout_fire;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    assign expired = (tmr_q == T_LAST);

    always_comb begin
        tmr_d         = (state_q == WAIT_B) ? tmr_q + 1'b1 : '0;
        rsp_timeout_d = timeout_fire | (rsp_timeout_q & (state_q == RSP) & ~rsp_ready);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tmr_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            tmr_q         <= tmr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign expired     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign b_hs         = bvalid & bready_q;
    assign timeout_fire = (state_q == WAIT_B) & ~b_hs & expired;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_resp_d  = rsp_resp_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                awaddr_d  = cmd_addr;
                wdata_d   = cmd_data;
                wstrb_d   = cmd_strb;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = SEND;
            end
            SEND: begin
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q & ~wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: if (b_hs || expired) begin
                // a real response in the expiry cycle takes priority over the timeout
                bready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_resp_d  = b_hs ? bresp : 2'b10;
                state_d     = RSP;
            end
            RSP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q == WAIT_B && state_d == RSP && rsp_resp_d != 2'b00 && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            err_count_q <= 8'd0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_resp_q  <= rsp_resp_d;
            err_count_q <= err_count_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign awvalid   = awvalid_q;
    assign awaddr    = awaddr_q;
    assign awprot    = 3'b000;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign bready    = bready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_resp  = rsp_resp_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_axi4_lite_wr_manager.sv
// tb_axi4_lite_wr_manager: directed self-checking bench for axi4_lite_wr_manager.
module tb_axi4_lite_wr_manager;
    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [7:0]  err_count;
    logic        busy;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = 2'b00;

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    axi4_lite_wr_manager #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .err_count(err_count), .busy(busy),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        tests++;
        if (rsp_valid !== 1'b1) begin
            $display("FAIL %s_wait_rsp rsp_valid=%b expected 1 within 50 cycles", name, rsp_valid);
            fails++;
        end
    endtask

    task automatic test_reset;
        areset = 1'b1;
        #2;
        tests++;
        if ({cmd_ready, awvalid, wvalid, bready, rsp_valid, rsp_timeout, busy} !== 7'b1000000) begin
            $display("FAIL reset_ctrl got %b expected 1000000", {cmd_ready, awvalid, wvalid, bready, rsp_valid, rsp_timeout, busy});
            fails++;
        end
        tests++;
        if ({err_count, rsp_resp, awprot, awaddr, wdata, wstrb} !== 81'h0) begin
            $display("FAIL reset_data err=%h resp=%b prot=%b awaddr=%h wdata=%h wstrb=%h expected all 0", err_count, rsp_resp, awprot, awaddr, wdata, wstrb);
            fails++;
        end
        @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    task automatic test_basic;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'h0000_0008; cmd_data = 32'hABCD_DEFA; cmd_strb = 4'hF;
        step();
        cmd_valid = 1'b0;
        tests++;
        if ({awvalid, wvalid, bready, rsp_valid, cmd_ready, busy} !== 6'b110001) begin
            $display("FAIL basic_t1_ctrl got %b expected 110001", {awvalid, wvalid, bready, rsp_valid, cmd_ready, busy});
            fails++;
        end
        tests++;
        if ({awaddr, wdata, wstrb} !== {32'h8, 32'hABCD_DEFA, 4'hF}) begin
            $display("FAIL basic_t1_payload awaddr=%h wdata=%h wstrb=%h expected 00000008 abcddefa f", awaddr, wdata, wstrb);
            fails++;
        end
        step();
        tests++;
        if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
            $display("FAIL basic_t2_ctrl got %b expected 0010", {awvalid, wvalid, bready, rsp_valid});
            fails++;
        end
        step();
        tests++;
        if ({bready, rsp_valid, rsp_timeout, rsp_resp, err_count} !== {3'b010, 2'b00, 8'd0}) begin
            $display("FAIL basic_t3_rsp bready=%b rsp_valid=%b tmo=%b resp=%b err=%0d expected 0 1 0 00 0", bready, rsp_valid, rsp_timeout, rsp_resp, err_count);
            fails++;
        end
        bvalid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            $display("FAIL basic_rsp_done got %b expected 010", {rsp_valid, cmd_ready, busy});
            fails++;
        end
    endtask

    task automatic test_aw_delay;
        awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'h0000_0010; cmd_data = 32'h1234_5678; cmd_strb = 4'h3;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic exp_w;
            exp_w = (i == 0);
            tests++;
            if ({awvalid, awaddr, bready, wvalid} !== {1'b1, 32'h10, 1'b0, exp_w}) begin
                $display("FAIL aw_delay_cycle%0d awvalid=%b awaddr=%h bready=%b wvalid=%b expected 1 00000010 0 %b", i, awvalid, awaddr, bready, wvalid, exp_w);
                fails++;
            end
            if (i == 3) awready = 1'b1;
            step();
        end
        tests++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            $display("FAIL aw_delay_wait_b got %b expected 001", {awvalid, wvalid, bready});
            fails++;
        end
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        tests++;
        if ({rsp_valid, rsp_resp} !== 3'b100) begin
            $display("FAIL aw_delay_rsp got %b expected 100", {rsp_valid, rsp_resp});
            fails++;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_err_resp;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            cmd_valid = 1'b1; cmd_addr = 32'h20 + 32'(4 * k); cmd_data = 32'(k); cmd_strb = 4'hF;
            step();
            cmd_valid = 1'b0;
            wait_rsp("err_resp");
            tests++;
            if ({rsp_resp, err_count} !== {2'b10, 8'(k)}) begin
                $display("FAIL err_resp_%0d resp=%b err=%0d expected 10 %0d", k, rsp_resp, err_count, k);
                fails++;
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic test_rsp_backpressure;
        bvalid = 1'b1; bresp = 2'b00; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_data = 32'h1111_1111; cmd_strb = 4'hF;
        step();
        wait_rsp("backpressure");
        cmd_addr = 32'h44; cmd_data = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({cmd_ready, awvalid, rsp_valid} !== 3'b001) begin
                $display("FAIL backpressure_hold%0d got %b expected 001", i, {cmd_ready, awvalid, rsp_valid});
                fails++;
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests++;
        if ({cmd_ready, awvalid, rsp_valid} !== 3'b100) begin
            $display("FAIL backpressure_release got %b expected 100", {cmd_ready, awvalid, rsp_valid});
            fails++;
        end
        step();
        cmd_valid = 1'b0;
        tests++;
        if ({awvalid, awaddr, wdata} !== {1'b1, 32'h44, 32'h2222_2222}) begin
            $display("FAIL backpressure_next awvalid=%b awaddr=%h wdata=%h expected 1 00000044 22222222", awvalid, awaddr, wdata);
            fails++;
        end
        wait_rsp("backpressure_next");
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        bvalid = 1'b0;
        step(); step(); step();
        tests++;
        if ({cmd_ready, awvalid, busy, err_count} !== {3'b100, 8'd3}) begin
            $display("FAIL backpressure_single cmd_ready=%b awvalid=%b busy=%b err=%0d expected 1 0 0 3", cmd_ready, awvalid, busy, err_count);
            fails++;
        end
    endtask

    task automatic test_reset_mid;
        awready = 1'b0; wready = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'h80; cmd_data = 32'h5555_AAAA; cmd_strb = 4'hF;
        step();
        cmd_valid = 1'b0;
        tests++;
        if ({awvalid, wvalid} !== 2'b11) begin
            $display("FAIL reset_mid_send got %b expected 11", {awvalid, wvalid});
            fails++;
        end
        areset = 1'b1;
        #1;
        tests++;
        if ({awvalid, wvalid, bready, rsp_valid, cmd_ready, busy, err_count} !== {6'b000010, 8'd0}) begin
            $display("FAIL reset_mid_async ctrl=%b err=%0d expected 000010 0", {awvalid, wvalid, bready, rsp_valid, cmd_ready, busy}, err_count);
            fails++;
        end
        @(posedge aclk);
        #1 areset = 1'b0;
        awready = 1'b1; wready = 1'b1;
    endtask

`ifdef AXI_WR_TIMEOUT_EN
    task automatic test_timeout;
        bvalid = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'hC0; cmd_data = 32'h0; cmd_strb = 4'h1;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({bready, rsp_valid} !== 2'b10) begin
                $display("FAIL timeout_wait%0d got %b expected 10", i, {bready, rsp_valid});
                fails++;
            end
            step();
        end
        tests++;
        if ({bready, rsp_valid, rsp_timeout, rsp_resp, err_count} !== {3'b011, 2'b10, 8'd1}) begin
            $display("FAIL timeout_fire bready=%b rsp_valid=%b tmo=%b resp=%b err=%0d expected 0 1 1 10 1", bready, rsp_valid, rsp_timeout, rsp_resp, err_count);
            fails++;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests++;
        if ({rsp_valid, rsp_timeout} !== 2'b00) begin
            $display("FAIL timeout_clear got %b expected 00", {rsp_valid, rsp_timeout});
            fails++;
        end
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin bvalid = 1'b1; bresp = 2'b00; end
            step();
        end
        bvalid = 1'b0;
        tests++;
        if ({rsp_valid, rsp_timeout, rsp_resp, err_count} !== {2'b10, 2'b00, 8'd1}) begin
            $display("FAIL timeout_real_wins rsp_valid=%b tmo=%b resp=%b err=%0d expected 1 0 00 1", rsp_valid, rsp_timeout, rsp_resp, err_count);
            fails++;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask
`else
    task automatic test_timeout;
        bvalid = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'hC0; cmd_data = 32'h0; cmd_strb = 4'h1;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            tests++;
            if ({bready, rsp_valid, rsp_timeout} !== 3'b100) begin
                $display("FAIL no_timeout_wait%0d got %b expected 100", i, {bready, rsp_valid, rsp_timeout});
                fails++;
            end
            step();
        end
        bvalid = 1'b1; bresp = 2'b01;
        step();
        bvalid = 1'b0;
        tests++;
        if ({bready, rsp_valid, rsp_timeout, rsp_resp, err_count} !== {3'b010, 2'b01, 8'd1}) begin
            $display("FAIL no_timeout_late_b bready=%b rsp_valid=%b tmo=%b resp=%b err=%0d expected 0 1 0 01 1", bready, rsp_valid, rsp_timeout, rsp_resp, err_count);
            fails++;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_basic();
        test_aw_delay();
        test_err_resp();
        test_rsp_backpressure();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
